// File: rtl/conv_8_32_packer.sv
// Byte-to-word packer: gathers four valid bytes, MSB byte first, into one 32-bit word.
// Optionally holds a partial word across valid gaps. Otherwise it aborts the word and flags it.
module conv_8_32_packer #(
   parameter bit GAP_TOLERANT = 1'b0,
   parameter int CNT_W        = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_L,
   input  logic             i_valid_in,
   input  logic [7:0]       i_data_in,
   output logic             o_valid_out,
   output logic [31:0]      o_data_out,
   output logic             o_abort_err,
   output logic [CNT_W-1:0] o_word_count
);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t           r_state;
   logic [1:0]       r_index;
   logic [23:0]      r_partial;
   logic [31:0]      r_dataOut;
   logic             r_validOut;
   logic             r_abortErr;
   logic [CNT_W-1:0] r_wordCount;

   // r_partial holds bytes 0..2. The 4th byte goes straight into the output word.
   always_ff @(posedge i_clk or negedge i_reset_L) begin
      if (!i_reset_L) begin
         r_state     <= IDLE;
         r_index     <= 2'd0;
         r_partial   <= 24'd0;
         r_dataOut   <= 32'd0;
         r_validOut  <= 1'b0;
         r_abortErr  <= 1'b0;
         r_wordCount <= '0;
      end else begin
         r_validOut <= 1'b0;
         r_abortErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_valid_in) begin
                  r_partial[23:16] <= i_data_in;
                  r_index          <= 2'd1;
                  r_state          <= COLLECT;
               end
            end
            COLLECT: begin
               if (i_valid_in) begin
                  if (r_index == 2'd3) begin
                     r_dataOut   <= {r_partial, i_data_in};
                     r_validOut  <= 1'b1;
                     r_wordCount <= r_wordCount + 1'b1;
                     r_index     <= 2'd0;
                     r_partial   <= 24'd0;
                     r_state     <= IDLE;
                  end else begin
                     case (r_index)
                        2'd1:    r_partial[15:8] <= i_data_in;
                        2'd2:    r_partial[7:0]  <= i_data_in;
                        default: r_partial[23:16] <= i_data_in;
                     endcase
                     r_index <= r_index + 2'd1;
                  end
               end else if (!GAP_TOLERANT) begin
                  r_abortErr <= 1'b1;
                  r_index    <= 2'd0;
                  r_partial  <= 24'd0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_valid_out  = r_validOut;
   assign o_data_out   = r_dataOut;
   assign o_abort_err  = r_abortErr;
   assign o_word_count = r_wordCount;

endmodule
